branch_predict_ctrl: RTL and testbench

- Owns the branch history table (BHT): 2^IDX_W two-bit saturating counters, indexed by PC.
- Sequences the predictor across the pipeline:
  - registered lookup in IF, result presented in ID;
  - counter update and mispredict detection in EX;
  - one-cycle recovery state after a mispredict;
  - branch and mispredict statistics counters.
- Sits between the IF/ID fetch logic and the EX branch-resolution unit.

---
 rtl/branch_predict_ctrl_pkg.sv | 26 ++
 rtl/branch_predict_ctrl_if.sv | 33 +++
 rtl/branch_predict_ctrl_bht_counter_next.sv | 14 +
 rtl/branch_predict_ctrl.sv | 108 ++++++++++
 tb/tb_branch_predict_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types, constants and saturating-counter helper for the branch predictor.
// Optional same-cycle forwarding is selected by the BHT_BYPASS_EN macro.
package bp_pkg;

    localparam int unsigned BP_IDX_W      = 6;
    localparam logic [1:0]  BP_INIT_STATE = 2'b01;

    localparam logic [1:0] ST_SNT = 2'd0;
    localparam logic [1:0] ST_WNT = 2'd1;
    localparam logic [1:0] ST_WT  = 2'd2;
    localparam logic [1:0] ST_ST  = 2'd3;

    localparam logic [0:0] FSM_IDLE    = 1'b0;
    localparam logic [0:0] FSM_RECOVER = 1'b1;

    typedef struct packed {
        logic       valid;
        logic [1:0] state;
    } bp_pred_t;

    function automatic logic [1:0] sat_next(input logic [1:0] s, input logic taken);
        if (taken) return (s == ST_ST)  ? ST_ST  : 2'(s + 2'd1);
        else       return (s == ST_SNT) ? ST_SNT : 2'(s - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Fetch/decode lookup and execute resolution signals of the branch predictor.
interface branch_predict_ctrl_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             if_valid;
    logic [PC_W-1:0]  if_pc;
    logic             id_stall;
    logic             id_pred_valid;
    logic [1:0]       id_pred_state;
    logic             id_pred_taken;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [PC_W-1:0]  ex_pc;
    logic [1:0]       ex_state;
    logic             ex_outcome;
    logic             flush;
    logic             recovering;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output if_valid, if_pc, id_stall, ex_valid, ex_is_branch, ex_pc, ex_state, ex_outcome,
        input  id_pred_valid, id_pred_state, id_pred_taken, flush, recovering,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_valid, if_pc, id_stall, ex_valid, ex_is_branch, ex_pc, ex_state, ex_outcome,
        output id_pred_valid, id_pred_state, id_pred_taken, flush, recovering,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_ctrl_bht_counter_next.sv
// Two-bit saturating next-state and mispredict decode for one resolved branch.
module bht_counter_next
    import bp_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next_state_c,
    output logic       mispred_c
);
    always_comb begin
        next_state_c = sat_next(state, taken);
        mispred_c    = state[1] ^ taken;
    end
endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch history table owner: registered IF lookup, EX update, one-cycle recovery, stats.
// Define BHT_BYPASS_EN to forward a same-cycle update to a colliding lookup.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W      = BP_IDX_W,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned CNT_W      = 16,
    parameter logic [1:0]  INIT_STATE = BP_INIT_STATE
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0]       bht [DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             upd_c;
    logic             mispred_c;
    logic             raw_mispred;
    logic [1:0]       upd_state;
    logic [1:0]       lookup_state;
    logic [0:0]       fsm_q;
    logic [0:0]       fsm_d;
    bp_pred_t         pred_q;
    bp_pred_t         pred_d;
    logic [CNT_W-1:0] branch_q;
    logic [CNT_W-1:0] mispred_q;

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];

    // One shared next-state instance feeds both the table write and the forward path.
    bht_counter_next u_next (
        .state        (bus.ex_state),
        .taken        (bus.ex_outcome),
        .next_state_c (upd_state),
        .mispred_c    (raw_mispred)
    );

    assign upd_c     = bus.ex_valid & bus.ex_is_branch;
    assign mispred_c = upd_c & raw_mispred;

    always_comb begin
        lookup_state = bht[if_idx];
`ifdef BHT_BYPASS_EN
        if (upd_c && (ex_idx == if_idx)) lookup_state = upd_state;
`endif
    end

    // Flush squashes ID even under stall; RECOVER drops the re-presented lookup.
    always_comb begin
        fsm_d  = mispred_c ? FSM_RECOVER : FSM_IDLE;
        pred_d = pred_q;
        if (mispred_c) begin
            pred_d.valid = 1'b0;
        end else if (bus.id_stall) begin
            pred_d = pred_q;
        end else if (fsm_q == FSM_RECOVER) begin
            pred_d.valid = 1'b0;
        end else if (bus.if_valid) begin
            pred_d.valid = 1'b1;
            pred_d.state = lookup_state;
        end else begin
            pred_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= FSM_IDLE;
            pred_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            pred_q <= pred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) bht[IDX_W'(i)] <= INIT_STATE;
        end else if (upd_c) begin
            bht[ex_idx] <= upd_state;
        end
    end

    // Statistics saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_q  <= '0;
            mispred_q <= '0;
        end else if (upd_c) begin
            if (branch_q != '1) branch_q <= branch_q + CNT_W'(1);
            if (mispred_c && (mispred_q != '1)) mispred_q <= mispred_q + CNT_W'(1);
        end
    end

    assign bus.id_pred_valid = pred_q.valid;
    assign bus.id_pred_state = pred_q.state;
    assign bus.id_pred_taken = pred_q.state[1];
    assign bus.flush         = mispred_c;
    assign bus.recovering    = (fsm_q == FSM_RECOVER);
    assign bus.branch_cnt    = branch_q;
    assign bus.mispred_cnt   = mispred_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl; a reference table model predicts every ID output.
module tb_branch_predict_ctrl;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 16;

    typedef struct { logic v; logic [1:0] s; } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predict_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
    branch_predict_ctrl_if #(.PC_W(PC_W), .CNT_W(4))     sbus ();

    branch_predict_ctrl #(.IDX_W(IDX_W), .PC_W(PC_W), .CNT_W(CNT_W), .INIT_STATE(2'b01))
        dut (.clk(clk), .rst(rst), .bus(bus));
    branch_predict_ctrl #(.IDX_W(IDX_W), .PC_W(PC_W), .CNT_W(4), .INIT_STATE(2'b01))
        dut4 (.clk(clk), .rst(rst), .bus(sbus));

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    logic [1:0]  mdl_bht [64];
    logic        mdl_valid, mdl_rec;
    logic [1:0]  mdl_pst;
    int unsigned mdl_br, mdl_mp;

    function automatic logic [1:0] ref_sat(input logic [1:0] s, input logic t);
        case ({s, t})
            3'b00_1: return 2'b01;  3'b00_0: return 2'b00;
            3'b01_1: return 2'b10;  3'b01_0: return 2'b00;
            3'b10_1: return 2'b11;  3'b10_0: return 2'b01;
            3'b11_1: return 2'b11;  default: return 2'b10;
        endcase
    endfunction

    function automatic logic [5:0] pidx(input logic [PC_W-1:0] pc);
        return pc[7:2];
    endfunction

    // Advance one clock: compute expected ID outputs from the model, push them, then update it.
    task automatic step();
        logic upd, misp;
        logic [1:0] nxt;
        exp_t e;
        upd  = bus.ex_valid & bus.ex_is_branch;
        misp = upd & (bus.ex_state[1] ^ bus.ex_outcome);
        nxt  = ref_sat(bus.ex_state, bus.ex_outcome);
        if (rst) begin
            for (int i = 0; i < 64; i++) mdl_bht[i] = 2'b01;
            mdl_valid = 1'b0; mdl_pst = 2'b00; mdl_rec = 1'b0; mdl_br = 0; mdl_mp = 0;
        end else begin
            if (misp) mdl_valid = 1'b0;
            else if (bus.id_stall) mdl_valid = mdl_valid;
            else if (mdl_rec) mdl_valid = 1'b0;
            else if (bus.if_valid) begin
                mdl_valid = 1'b1;
                mdl_pst   = mdl_bht[pidx(bus.if_pc)];
`ifdef BHT_BYPASS_EN
                if (upd && pidx(bus.ex_pc) == pidx(bus.if_pc)) mdl_pst = nxt;
`endif
            end else mdl_valid = 1'b0;
            if (upd) begin
                mdl_bht[pidx(bus.ex_pc)] = nxt;
                if (mdl_br != 65535) mdl_br++;
                if (misp && mdl_mp != 65535) mdl_mp++;
            end
            mdl_rec = misp;
        end
        e.v = mdl_valid; e.s = mdl_pst;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic set_idle();
        bus.if_valid = 1'b0; bus.if_pc = '0; bus.id_stall = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_pc = '0;
        bus.ex_state = 2'b00; bus.ex_outcome = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; set_idle();
        step(); step();
        void'(q.pop_front()); e = q.pop_front();
        checks++; if (bus.id_pred_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.id_pred_valid); end
        checks++; if (bus.id_pred_state !== 2'b00) begin errors++; $display("FAIL reset_state got %0b exp 00", bus.id_pred_state); end
        checks++; if (bus.recovering !== 1'b0) begin errors++; $display("FAIL reset_recovering got %0b exp 0", bus.recovering); end
        checks++; if (bus.branch_cnt !== 16'd0 || bus.mispred_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.branch_cnt, bus.mispred_cnt); end
        rst = 1'b0;
        for (int a = 0; a <= 'hFC; a += 4) begin
            bus.if_valid = 1'b1; bus.if_pc = PC_W'(a);
            step(); e = q.pop_front();
            checks++; if (bus.id_pred_valid !== e.v || bus.id_pred_state !== e.s || e.s !== 2'b01) begin
                errors++; $display("FAIL reset_lookup pc=%0h got %0b/%0b exp %0b/%0b", a, bus.id_pred_valid, bus.id_pred_state, e.v, e.s);
            end
        end
        set_idle(); step(); void'(q.pop_front());
    endtask

    task automatic test_training();
        exp_t e;
        logic exp_flush;
        int br0, mp0;
        br0 = mdl_br; mp0 = mdl_mp;
        for (int k = 0; k < 3; k++) begin
            set_idle(); bus.if_valid = 1'b1; bus.if_pc = 32'h40;
            step(); e = q.pop_front();
            checks++; if (bus.id_pred_valid !== e.v || bus.id_pred_state !== e.s) begin
                errors++; $display("FAIL train_lookup%0d got %0b/%0b exp %0b/%0b", k, bus.id_pred_valid, bus.id_pred_state, e.v, e.s);
            end
            checks++; if (bus.id_pred_taken !== e.s[1]) begin errors++; $display("FAIL train_taken%0d got %0b exp %0b", k, bus.id_pred_taken, e.s[1]); end
            set_idle(); bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'h40;
            bus.ex_state = mdl_pst; bus.ex_outcome = 1'b1;
            exp_flush = (k == 0);
            #1;
            checks++; if (bus.flush !== exp_flush) begin errors++; $display("FAIL train_flush%0d got %0b exp %0b", k, bus.flush, exp_flush); end
            step(); void'(q.pop_front());
            set_idle(); step(); void'(q.pop_front());
        end
        set_idle(); bus.if_valid = 1'b1; bus.if_pc = 32'h40;
        step(); e = q.pop_front();
        checks++; if (bus.id_pred_state !== 2'b11 || e.s !== 2'b11) begin errors++; $display("FAIL train_final got %0b exp 11", bus.id_pred_state); end
        checks++; if (bus.mispred_cnt !== 16'(mp0 + 1) || bus.branch_cnt !== 16'(br0 + 3)) begin
            errors++; $display("FAIL train_cnt got %0d/%0d exp %0d/%0d", bus.branch_cnt, bus.mispred_cnt, br0 + 3, mp0 + 1);
        end
        set_idle(); step(); void'(q.pop_front());
    endtask

    task automatic test_recovery();
        exp_t e;
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'h40;
        bus.ex_state = 2'b11; bus.ex_outcome = 1'b0;
        bus.if_valid = 1'b1; bus.if_pc = 32'h44;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL recov_flush got %0b exp 1", bus.flush); end
        step(); e = q.pop_front();
        checks++; if (bus.recovering !== 1'b1) begin errors++; $display("FAIL recov_state got %0b exp 1", bus.recovering); end
        checks++; if (bus.id_pred_valid !== e.v || e.v !== 1'b0) begin errors++; $display("FAIL recov_valid got %0b exp 0", bus.id_pred_valid); end
        set_idle(); bus.if_valid = 1'b1; bus.if_pc = 32'h44;
        step(); e = q.pop_front();
        checks++; if (bus.id_pred_valid !== e.v || bus.recovering !== 1'b0) begin
            errors++; $display("FAIL recov_exit got %0b/%0b exp %0b/0", bus.id_pred_valid, bus.recovering, e.v);
        end
        bus.if_pc = 32'h40;
        step(); e = q.pop_front();
        checks++; if (bus.id_pred_state !== 2'b10 || bus.id_pred_valid !== 1'b1) begin
            errors++; $display("FAIL recov_entry got %0b/%0b exp 1/10", bus.id_pred_valid, bus.id_pred_state);
        end
        set_idle(); step(); void'(q.pop_front());
    endtask

    task automatic test_collision();
        exp_t e;
        logic [1:0] want;
        set_idle();
        bus.if_valid = 1'b1; bus.if_pc = 32'h80;
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'h80;
        bus.ex_state = 2'b01; bus.ex_outcome = 1'b1;
`ifdef BHT_BYPASS_EN
        want = 2'b10;
`else
        want = 2'b01;
`endif
        step(); e = q.pop_front();
        checks++; if (bus.id_pred_valid !== e.v || bus.id_pred_state !== e.s) begin
            errors++; $display("FAIL collide_model got %0b/%0b exp %0b/%0b", bus.id_pred_valid, bus.id_pred_state, e.v, e.s);
        end
        set_idle(); bus.if_valid = 1'b1; bus.if_pc = 32'h80;
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'h80;
        bus.ex_state = 2'b01; bus.ex_outcome = 1'b1; bus.id_stall = 1'b0;
        set_idle(); step(); void'(q.pop_front());
        bus.if_valid = 1'b1; bus.if_pc = 32'h80;
        step(); e = q.pop_front();
        checks++; if (bus.id_pred_state !== 2'b10) begin errors++; $display("FAIL collide_entry got %0b exp 10", bus.id_pred_state); end
        checks++; if (want !== 2'b10 && want !== 2'b01) begin errors++; $display("FAIL collide_want got %0b", want); end
        set_idle(); step(); void'(q.pop_front());
    endtask

    task automatic test_stall_alias();
        exp_t e;
        set_idle(); bus.if_valid = 1'b1; bus.if_pc = 32'h0C;
        step(); e = q.pop_front();
        checks++; if (bus.id_pred_valid !== 1'b1 || bus.id_pred_state !== e.s) begin
            errors++; $display("FAIL stall_pre got %0b/%0b exp 1/%0b", bus.id_pred_valid, bus.id_pred_state, e.s);
        end
        bus.id_stall = 1'b1; bus.if_pc = 32'h40;
        for (int k = 0; k < 3; k++) begin
            step(); e = q.pop_front();
            checks++; if (bus.id_pred_valid !== e.v || bus.id_pred_state !== e.s || e.s !== 2'b01) begin
                errors++; $display("FAIL stall_hold%0d got %0b/%0b exp %0b/%0b", k, bus.id_pred_valid, bus.id_pred_state, e.v, e.s);
            end
        end
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'h104;
        bus.ex_state = 2'b01; bus.ex_outcome = 1'b0;
        step(); void'(q.pop_front());
        set_idle(); bus.if_valid = 1'b1; bus.if_pc = 32'h004;
        step(); e = q.pop_front();
        checks++; if (bus.id_pred_state !== 2'b00 || e.s !== 2'b00) begin errors++; $display("FAIL alias got %0b exp 00", bus.id_pred_state); end
        set_idle(); step(); void'(q.pop_front());
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic exp_flush;
        for (int k = 0; k < 60; k++) begin
            bus.if_valid     = 1'($urandom_range(0, 1));
            bus.if_pc        = PC_W'($urandom_range(0, 7) * 4 + 32'h200);
            bus.id_stall     = ($urandom_range(0, 5) == 0);
            bus.ex_valid     = 1'($urandom_range(0, 1));
            bus.ex_is_branch = ($urandom_range(0, 3) != 0);
            bus.ex_pc        = PC_W'($urandom_range(0, 7) * 4 + 32'h200);
            bus.ex_state     = mdl_bht[pidx(bus.ex_pc)];
            bus.ex_outcome   = 1'($urandom_range(0, 1));
            exp_flush = bus.ex_valid & bus.ex_is_branch & (bus.ex_state[1] ^ bus.ex_outcome);
            #1;
            checks++; if (bus.flush !== exp_flush) begin errors++; $display("FAIL b2b_flush%0d got %0b exp %0b", k, bus.flush, exp_flush); end
            step(); e = q.pop_front();
            checks++; if (bus.id_pred_valid !== e.v || bus.id_pred_state !== e.s || bus.recovering !== mdl_rec) begin
                errors++; $display("FAIL b2b_out%0d got %0b/%0b/%0b exp %0b/%0b/%0b", k, bus.id_pred_valid, bus.id_pred_state, bus.recovering, e.v, e.s, mdl_rec);
            end
        end
        checks++; if (bus.branch_cnt !== 16'(mdl_br) || bus.mispred_cnt !== 16'(mdl_mp)) begin
            errors++; $display("FAIL b2b_cnt got %0d/%0d exp %0d/%0d", bus.branch_cnt, bus.mispred_cnt, mdl_br, mdl_mp);
        end
        set_idle(); step(); void'(q.pop_front()); step(); void'(q.pop_front());
    endtask

    task automatic test_reset_mid();
        exp_t e;
        set_idle();
        bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'h40;
        bus.ex_state = 2'b00; bus.ex_outcome = 1'b1; bus.if_valid = 1'b1; bus.if_pc = 32'h40;
        rst = 1'b1;
        step(); void'(q.pop_front());
        rst = 1'b0;
        checks++; if (bus.recovering !== 1'b0 || bus.id_pred_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_fsm got %0b/%0b exp 0/0", bus.recovering, bus.id_pred_valid);
        end
        checks++; if (bus.branch_cnt !== 16'd0 || bus.mispred_cnt !== 16'd0) begin
            errors++; $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", bus.branch_cnt, bus.mispred_cnt);
        end
        set_idle(); bus.if_valid = 1'b1; bus.if_pc = 32'h40;
        step(); e = q.pop_front();
        checks++; if (bus.id_pred_state !== 2'b01 || e.s !== 2'b01) begin errors++; $display("FAIL rstmid_entry got %0b exp 01", bus.id_pred_state); end
        set_idle();
    endtask

    task automatic test_saturation();
        sbus.ex_valid = 1'b1; sbus.ex_is_branch = 1'b1; sbus.ex_pc = 32'h10;
        sbus.ex_state = 2'b01; sbus.ex_outcome = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            checks++; if (sbus.flush !== 1'b1) begin errors++; $display("FAIL sat_flush%0d got %0b exp 1", k, sbus.flush); end
            step(); void'(q.pop_front());
        end
        checks++; if (sbus.mispred_cnt !== 4'd15 || sbus.branch_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_cnt got %0d/%0d exp 15/15", sbus.branch_cnt, sbus.mispred_cnt);
        end
        checks++; if (sbus.recovering !== 1'b1) begin errors++; $display("FAIL sat_recover got %0b exp 1", sbus.recovering); end
        sbus.ex_valid = 1'b0;
        step(); void'(q.pop_front());
        checks++; if (sbus.recovering !== 1'b0) begin errors++; $display("FAIL sat_exit got %0b exp 0", sbus.recovering); end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        sbus.if_valid = 1'b0; sbus.if_pc = '0; sbus.id_stall = 1'b0;
        sbus.ex_valid = 1'b0; sbus.ex_is_branch = 1'b0; sbus.ex_pc = '0;
        sbus.ex_state = 2'b00; sbus.ex_outcome = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_training();
        test_recovery();
        test_collision();
        test_stall_alias();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
